// File: rtl/ex_div_unit_pkg.sv
// Shared EX-stage divider definitions: FSM state encoding, default width and
// result field placement ({HI=remainder, LO=quotient}).
package ex_div_unit_pkg;

  localparam int DIV_WIDTH  = 32;
  localparam int DIV_LO_LSB = 0;   // quotient at [W-1:0], remainder directly above it

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_FIN  = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/ex_div_unit_step.sv
// One radix-2 restoring division step: shift the next dividend bit into the
// partial remainder, subtract the divisor if it fits, and emit the quotient bit.
module div_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shf;
  logic [WIDTH:0] diff;
  logic           fits;

  assign shf  = {rem_i, quo_i[WIDTH-1]};
  assign fits = (shf >= {1'b0, dvs_i});
  assign diff = shf - {1'b0, dvs_i};

  always_comb begin
    quo_o = {quo_i[WIDTH-2:0], fits};
    rem_o = fits ? diff[WIDTH-1:0] : shf[WIDTH-1:0];
  end

endmodule

// File: rtl/ex_div_unit.sv
// Multi-cycle signed/unsigned restoring divider for the EX stage. Holds the
// pipeline via stall until {remainder, quotient} is ready in the DONE cycle.
module ex_div_unit
  import ex_div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               sign_i,
  input  logic [WIDTH-1:0]   dividend_i,
  input  logic [WIDTH-1:0]   divisor_i,
  input  logic               flush_i,
  output logic               stall_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               div_by_zero_o,
  output logic [2*WIDTH-1:0] result_o
);

  localparam int CNT_W  = $clog2(WIDTH);
  localparam int HI_LSB = DIV_LO_LSB + WIDTH;

  div_state_e         state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   rem_q, quo_q, dvs_q;
  logic               qneg_q, rneg_q, zero_q;
  logic               busy_q, done_q, div_by_zero_q;
  logic [2*WIDTH-1:0] result_q;

  logic [WIDTH-1:0]   rem_d, quo_d;
  logic [WIDTH-1:0]   dvd_abs, dvs_abs;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // Magnitudes only for signed ops; the sign is re-applied in FIN.
  assign dvd_abs = (sign_i && dividend_i[WIDTH-1]) ? (~dividend_i + 1'b1) : dividend_i;
  assign dvs_abs = (sign_i && divisor_i[WIDTH-1])  ? (~divisor_i + 1'b1)  : divisor_i;

  div_iter_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (rem_d),
    .quo_o (quo_d)
  );

  // Divide by zero: remainder already equals the original dividend after the
  // sign fix-up, so only the quotient needs forcing.
  assign quo_fix = zero_q ? '1 : (qneg_q ? (~quo_q + 1'b1) : quo_q);
  assign rem_fix = rneg_q ? (~rem_q + 1'b1) : rem_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= DIV_IDLE;
      cnt_q         <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      dvs_q         <= '0;
      qneg_q        <= 1'b0;
      rneg_q        <= 1'b0;
      zero_q        <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      div_by_zero_q <= 1'b0;
      result_q      <= '0;
    end else if (flush_i) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            state_q <= DIV_BUSY;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= dvd_abs;
            dvs_q   <= dvs_abs;
            qneg_q  <= sign_i & (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
            rneg_q  <= sign_i & dividend_i[WIDTH-1];
            zero_q  <= (divisor_i == '0);
          end
        end
        DIV_BUSY: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH-1)) state_q <= DIV_FIN;
        end
        DIV_FIN: begin
          result_q[DIV_LO_LSB +: WIDTH] <= quo_fix;
          result_q[HI_LSB +: WIDTH]     <= rem_fix;
          div_by_zero_q                 <= zero_q;
          busy_q                        <= 1'b0;
          done_q                        <= 1'b1;
          state_q                       <= DIV_DONE;
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= DIV_IDLE;
        end
      endcase
    end
  end

  // Combinational so the pipeline freezes in the very cycle the div arrives.
  assign stall_o = ((state_q == DIV_IDLE) && start_i && !flush_i) ||
                   (state_q == DIV_BUSY) || (state_q == DIV_FIN);

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign div_by_zero_o = div_by_zero_q;
  assign result_o      = result_q;

endmodule

// File: tb/tb_ex_div_unit.sv
// Directed + randomized bench for ex_div_unit; expected results come from a
// longint arithmetic model of the divide rules.
module tb_ex_div_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, sgn, flush;
  logic [W-1:0]  dvd, dvs;
  logic          stall, busy, done, dbz;
  logic [2*W-1:0] result;

  int checks   = 0;
  int failures = 0;
  logic [63:0] last_res;

  ex_div_unit #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start),
    .sign_i        (sgn),
    .dividend_i    (dvd),
    .divisor_i     (dvs),
    .flush_i       (flush),
    .stall_o       (stall),
    .busy_o        (busy),
    .done_o        (done),
    .div_by_zero_o (dbz),
    .result_o      (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_div(input bit s, input logic [31:0] a, input logic [31:0] b);
    longint x, y, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    x = s ? longint'($signed(a)) : longint'({32'd0, a});
    y = s ? longint'($signed(b)) : longint'({32'd0, b});
    q = x / y;
    r = x % y;
    return {r[31:0], q[31:0]};
  endfunction

  // Entered at the start of cycle 0 (just after a rising edge); leaves at the
  // start of the cycle after DONE with start still high.
  task automatic run_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] er, input bit ez, input string tag);
    start = 1'b1; sgn = s; dvd = a; dvs = b;
    for (int c = 0; c <= W + 2; c++) begin
      @(negedge clk);
      chk({tag, " stall"}, 64'(stall), 64'(c <= W + 1));
      chk({tag, " done"},  64'(done),  64'(c == W + 2));
      chk({tag, " busy"},  64'(busy),  64'(c >= 1 && c <= W + 1));
      if (c == W + 1) chk({tag, " held"}, result, last_res);
      if (c == W + 2) begin
        chk({tag, " result"}, result, er);
        chk({tag, " dbz"}, 64'(dbz), 64'(ez));
      end
      @(posedge clk); #1;
    end
    last_res = er;
  endtask

  initial begin
    bit          s;
    logic [31:0] a, b;
    bit          saw_done;

    rst = 1'b1; start = 1'b0; sgn = 1'b0; flush = 1'b0; dvd = '0; dvs = '0;
    last_res = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset stall", 64'(stall), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset dbz", 64'(dbz), 64'd0);
    chk("reset result", result, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases chained back-to-back: start never drops between them.
    run_div(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 1'b0, "u100/7");
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 1'b0, "s-7/2");
    run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 64'h00000001_FFFFFFFD, 1'b0, "s7/-2");
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000, 1'b0, "smin/-1");
    run_div(1'b0, 32'h0000_1234, 32'd0, 64'h00001234_FFFFFFFF, 1'b1, "u/0");
    run_div(1'b1, 32'hFFFF_FF00, 32'd0, 64'hFFFFFF00_FFFFFFFF, 1'b1, "s-256/0");
    start = 1'b0;
    @(negedge clk);
    chk("idle stall", 64'(stall), 64'd0);
    chk("idle done", 64'(done), 64'd0);
    @(posedge clk); #1;

    // Flush in cycle 10 of a division, with start still asserted.
    start = 1'b1; sgn = 1'b0; dvd = 32'd5000; dvs = 32'd3;
    repeat (10) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(negedge clk);
    chk("flush busy-stall", 64'(stall), 64'd1);
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("post-flush stall", 64'(stall), 64'd0);
    chk("post-flush busy", 64'(busy), 64'd0);
    saw_done = 1'b0;
    repeat (W + 6) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("flush no done", 64'(saw_done), 64'd0);
    chk("flush result kept", result, last_res);

    // Flush beats start while idle.
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk("flush over start stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush over start busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    run_div(1'b0, 32'd5000, 32'd3, 64'h00000002_00000682, 1'b0, "after flush");

    // Randomized operands against the arithmetic model.
    for (int i = 0; i < 30; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 4))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = -$urandom_range(1, 15);
        3:       b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      if (i % 7 == 3) a = 32'h8000_0000;
      run_div(s, a, b, ref_div(s, a, b), b == 32'd0, $sformatf("rnd%0d", i));
      if (i % 5 == 4) begin
        start = 1'b0;
        @(posedge clk); #1;
      end
    end

    // Asynchronous reset in the middle of BUSY.
    start = 1'b1; sgn = 1'b1; dvd = 32'h1357_9BDF; dvs = 32'd11;
    repeat (6) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("pre-rst busy", 64'(busy), 64'd1);
    #2;
    start = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst stall", 64'(stall), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst dbz", 64'(dbz), 64'd0);
    chk("rst result", result, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    last_res = '0;
    @(posedge clk); #1;
    run_div(1'b1, 32'h1357_9BDF, 32'd11, ref_div(1'b1, 32'h1357_9BDF, 32'd11), 1'b0, "after rst");
    start = 1'b0;
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
